// File: rtl/simon_pkg.sv
// -----------------------------------------------------------------------------
// simon_pkg
// Shared definitions for the Simon sequence generator:
//   - colour codes as stored in the sequence RAM
//   - Galois LFSR feedback mask and single-step function
//   - sequence FSM state encoding
//   - colour code to one-hot {YELLO, RE, BLU, GREE} decode
// -----------------------------------------------------------------------------
package simon_pkg;

    localparam logic [1:0] COL_GREEN  = 2'b00;
    localparam logic [1:0] COL_YELLOW = 2'b01;
    localparam logic [1:0] COL_BLUE   = 2'b10;
    localparam logic [1:0] COL_RED    = 2'b11;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_DONE = 2'b10
    } seq_state_e;

    // One Galois step, shifting right; the mask is applied when a 1 falls out.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt_s;
        if (cur[0]) begin
            nxt_s = (cur >> 1) ^ LFSR_MASK;
        end else begin
            nxt_s = cur >> 1;
        end
        return nxt_s;
    endfunction

    // Colour code to one-hot lines ordered {YELLO, RE, BLU, GREE}.
    function automatic logic [3:0] colour_onehot(input logic [1:0] code);
        logic [3:0] oh_s;
        case (code)
            COL_YELLOW: oh_s = 4'b1000;
            COL_RED:    oh_s = 4'b0100;
            COL_BLUE:   oh_s = 4'b0010;
            COL_GREEN:  oh_s = 4'b0001;
            default:    oh_s = 4'b0000;
        endcase
        return oh_s;
    endfunction

endpackage

// File: rtl/simon_lfsr16.sv
// -----------------------------------------------------------------------------
// simon_lfsr16
// Free-running 16-bit Galois LFSR (right shift, mask 16'hB400). It advances on
// every clock edge so the moment the player presses START decides the colour
// sequence. A zero seed would lock the register at zero, so it is replaced by
// 16'h0001.
// Ports:
//   CLK      in   system clock, rising edge
//   RESET_N  in   asynchronous active-low reset (loads the seed)
//   CODE     out  low two bits of the current state, used as a colour code
// -----------------------------------------------------------------------------
module simon_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    output logic [1:0] CODE
);
    import simon_pkg::*;

    localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_r;

    // LFSR state register: seed on reset, one Galois step every edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lfsr_r <= SEED_SAFE;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign CODE = lfsr_r[1:0];

endmodule

// File: rtl/simon_seq_gen.sv
// -----------------------------------------------------------------------------
// simon_seq_gen
// Colour-sequence source for the Simon game. While GEN is high it fills a
// DEPTH-entry RAM with colour codes taken from a free-running LFSR, then holds
// RAND_DONE high until GEN drops. The stored colour at RD_IDX is presented as
// registered one-hot colour lines.
// Ports:
//   CLK        in   system clock, rising edge
//   RESET_N    in   asynchronous active-low reset
//   GEN        in   fill request (level)
//   RD_IDX     in   sequence index to read
//   RAND_DONE  out  fill complete, held while GEN stays high
//   BUSY       out  fill in progress
//   SEQ_VALID  out  a complete sequence is stored
//   YELLO/RE/BLU/GREE  out  one-hot colour of entry RD_IDX (1-cycle latency)
// -----------------------------------------------------------------------------
module simon_seq_gen #(
    parameter int          DEPTH = 16,
    parameter int          IDX_W = 4,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             GEN,
    input  logic [IDX_W-1:0] RD_IDX,
    output logic             RAND_DONE,
    output logic             BUSY,
    output logic             SEQ_VALID,
    output logic             YELLO,
    output logic             RE,
    output logic             BLU,
    output logic             GREE
);
    import simon_pkg::*;

    // RAM is sized to the full index space so any RD_IDX addresses a real row;
    // rows at DEPTH and above are never written and are masked on read.
    localparam int               MEM_N    = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    seq_state_e       state_r;
    seq_state_e       state_s;
    logic [IDX_W-1:0] wr_idx_r;
    logic [IDX_W-1:0] wr_idx_s;
    logic             wr_en_s;
    logic             rand_done_r;
    logic             rand_done_s;
    logic             busy_r;
    logic             busy_s;
    logic             seq_valid_r;
    logic             seq_valid_s;
    logic [3:0]       colour_r;
    logic [3:0]       colour_s;
    logic [1:0]       mem_r [MEM_N];
    logic [1:0]       code_s;
    logic [31:0]      rd_idx_ext_s;

    simon_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .CODE    (code_s)
    );

    assign rd_idx_ext_s = 32'(RD_IDX);

    // Next-state and next-flag logic of the fill FSM.
    always_comb begin
        state_s     = state_r;
        wr_idx_s    = wr_idx_r;
        wr_en_s     = 1'b0;
        rand_done_s = rand_done_r;
        busy_s      = busy_r;
        seq_valid_s = seq_valid_r;
        case (state_r)
            ST_IDLE: begin
                rand_done_s = 1'b0;
                if (GEN) begin
                    state_s     = ST_FILL;
                    wr_idx_s    = IDX_ZERO;
                    busy_s      = 1'b1;
                    seq_valid_s = 1'b0;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_FILL: begin
                if (!GEN) begin
                    // Abort: whatever was written is no longer a valid sequence.
                    state_s     = ST_IDLE;
                    wr_idx_s    = IDX_ZERO;
                    busy_s      = 1'b0;
                    seq_valid_s = 1'b0;
                end else begin
                    wr_en_s = 1'b1;
                    if (wr_idx_r == LAST_IDX) begin
                        state_s     = ST_DONE;
                        wr_idx_s    = IDX_ZERO;
                        busy_s      = 1'b0;
                        rand_done_s = 1'b1;
                        seq_valid_s = 1'b1;
                    end else begin
                        wr_idx_s = wr_idx_r + IDX_ONE;
                    end
                end
            end
            ST_DONE: begin
                // Stay here while GEN is held so a level request cannot refill.
                if (!GEN) begin
                    state_s     = ST_IDLE;
                    rand_done_s = 1'b0;
                end else begin
                    rand_done_s = 1'b1;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                wr_idx_s    = IDX_ZERO;
                rand_done_s = 1'b0;
                busy_s      = 1'b0;
                seq_valid_s = 1'b0;
            end
        endcase
    end

    // Read-side decode; a fill about to start wins over any read this edge.
    always_comb begin
        colour_s = 4'b0000;
        if (seq_valid_r && (state_r != ST_FILL) && !((state_r == ST_IDLE) && GEN)
            && (rd_idx_ext_s < 32'(DEPTH))) begin
            colour_s = colour_onehot(mem_r[RD_IDX]);
        end else begin
            colour_s = 4'b0000;
        end
    end

    // FSM state, write pointer and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r     <= ST_IDLE;
            wr_idx_r    <= IDX_ZERO;
            rand_done_r <= 1'b0;
            busy_r      <= 1'b0;
            seq_valid_r <= 1'b0;
            colour_r    <= 4'b0000;
        end else begin
            state_r     <= state_s;
            wr_idx_r    <= wr_idx_s;
            rand_done_r <= rand_done_s;
            busy_r      <= busy_s;
            seq_valid_r <= seq_valid_s;
            colour_r    <= colour_s;
        end
    end

    // Sequence RAM write port; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            mem_r[wr_idx_r] <= code_s;
        end
    end

    assign RAND_DONE = rand_done_r;
    assign BUSY      = busy_r;
    assign SEQ_VALID = seq_valid_r;
    assign YELLO     = colour_r[3];
    assign RE        = colour_r[2];
    assign BLU       = colour_r[1];
    assign GREE      = colour_r[0];

endmodule

// File: tb/tb_simon_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_simon_seq_gen
// Scoreboard bench: stimulus pushes expected values stamped with the clock
// edge after which they must hold; a monitor compares at every falling edge.
// Three builds: DEPTH=16 (main), DEPTH=12, and SEED=0.
// Output vectors are {RAND_DONE, BUSY, SEQ_VALID, YELLO, RE, BLU, GREE}.
// -----------------------------------------------------------------------------
module tb_simon_seq_gen;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       GEN = 1'b0;
    logic [3:0] RD_IDX = 4'd0;
    logic       gen_z = 1'b0;
    logic [3:0] rd_z = 4'd0;

    logic a_rd, a_busy, a_sv, a_y, a_r, a_b, a_g;
    logic b_rd, b_busy, b_sv, b_y, b_r, b_b, b_g;
    logic z_rd, z_busy, z_sv, z_y, z_r, z_b, z_g;

    simon_seq_gen #(.DEPTH(16), .IDX_W(4), .SEED(16'hACE1)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .GEN(GEN), .RD_IDX(RD_IDX),
        .RAND_DONE(a_rd), .BUSY(a_busy), .SEQ_VALID(a_sv),
        .YELLO(a_y), .RE(a_r), .BLU(a_b), .GREE(a_g));

    simon_seq_gen #(.DEPTH(12), .IDX_W(4), .SEED(16'hACE1)) u_d12 (
        .CLK(CLK), .RESET_N(RESET_N), .GEN(GEN), .RD_IDX(RD_IDX),
        .RAND_DONE(b_rd), .BUSY(b_busy), .SEQ_VALID(b_sv),
        .YELLO(b_y), .RE(b_r), .BLU(b_b), .GREE(b_g));

    simon_seq_gen #(.DEPTH(16), .IDX_W(4), .SEED(16'h0000)) u_z (
        .CLK(CLK), .RESET_N(RESET_N), .GEN(gen_z), .RD_IDX(rd_z),
        .RAND_DONE(z_rd), .BUSY(z_busy), .SEQ_VALID(z_sv),
        .YELLO(z_y), .RE(z_r), .BLU(z_b), .GREE(z_g));

    always #5 CLK = ~CLK;

    wire [15:0] act_main = {9'd0, a_rd, a_busy, a_sv, a_y, a_r, a_b, a_g};
    wire [15:0] act_d12  = {9'd0, b_rd, b_busy, b_sv, b_y, b_r, b_b, b_g};

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference LFSR, stepped with the same clock and reset as the DUTs.
    function automatic logic [15:0] step(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    logic [15:0] m_lfsr = 16'hACE1;
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) m_lfsr <= 16'hACE1;
        else          m_lfsr <= step(m_lfsr);
    end

    // {YELLO, RE, BLU, GREE}: 00 green, 01 yellow, 10 blue, 11 red.
    function automatic logic [3:0] oh(input logic [1:0] c);
        case (c)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b1000;
            2'b10:   return 4'b0010;
            default: return 4'b0100;
        endcase
    endfunction

    function automatic logic [15:0] ov(input logic rd, input logic busy,
                                       input logic sv, input logic [3:0] col);
        return {9'd0, rd, busy, sv, col};
    endfunction

    logic [1:0] codes [16];

    task automatic load_codes(input logic [15:0] start);
        logic [15:0] x;
        x = start;
        for (int i = 0; i < 16; i++) begin
            codes[i] = x[1:0];
            x = step(x);
        end
    endtask

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];

    // sel: 0 main outputs, 1 DEPTH=12 outputs, 2 main lfsr, 3 SEED=0 lfsr
    task automatic sb_push(input int sel, input int dly, input logic [15:0] exp,
                           input string name);
        chk_t e;
        e.cyc  = cyc + dly;
        e.sel  = sel;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compare every expectation due at this cycle.
    initial begin
        logic [15:0] act;
        forever begin
            @(negedge CLK);
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc <= cyc) begin
                    case (q[i].sel)
                        0:       act = act_main;
                        1:       act = act_d12;
                        2:       act = u_dut.u_lfsr.lfsr_r;
                        default: act = u_z.u_lfsr.lfsr_r;
                    endcase
                    n_cmp++;
                    if (q[i].cyc < cyc) begin
                        n_bad++;
                        $display("FAIL %s: check missed, due cycle %0d, now %0d",
                                 q[i].name, q[i].cyc, cyc);
                    end else if (act !== q[i].exp) begin
                        n_bad++;
                        $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)",
                                 q[i].name, act, q[i].exp, cyc);
                    end
                    q.delete(i);
                end
            end
        end
    end

    logic [15:0] zero7;
    logic [15:0] busy7;

    initial begin
        zero7 = ov(1'b0, 1'b0, 1'b0, 4'b0000);
        busy7 = ov(1'b0, 1'b1, 1'b0, 4'b0000);

        // ---- reset state, then GEN high at the first edge ----
        tick(); tick();
        sb_push(0, 0, zero7, "rst_out");
        sb_push(1, 0, zero7, "rst_out_d12");
        sb_push(2, 0, 16'hACE1, "rst_lfsr");
        sb_push(3, 0, 16'h0001, "rst_lfsr_seed0");
        RESET_N = 1'b1;
        GEN = 1'b1;
        sb_push(2, 1, 16'hE270, "lfsr_step1");
        sb_push(2, 2, 16'h7138, "lfsr_step2");
        sb_push(2, 3, 16'h389C, "lfsr_step3");
        sb_push(2, 4, 16'h1C4E, "lfsr_step4");
        sb_push(3, 1, 16'hB400, "seed0_step1");
        sb_push(3, 2, 16'h5A00, "seed0_step2");
        for (int i = 1; i <= 16; i++) sb_push(0, i, busy7, "fill_busy");
        sb_push(0, 17, ov(1'b1, 1'b0, 1'b1, 4'b0000), "rand_done_edge17");
        for (int i = 1; i <= 12; i++) sb_push(1, i, busy7, "fill_busy_d12");
        sb_push(1, 13, ov(1'b1, 1'b0, 1'b1, 4'b0000), "rand_done_d12_edge13");
        sb_push(1, 14, ov(1'b1, 1'b0, 1'b1, 4'b0001), "d12_idx0_green");
        sb_push(0, 18, ov(1'b1, 1'b0, 1'b1, 4'b0001), "idx0_green");
        repeat (18) tick();

        // first four entries by hand: green, green, green, blue
        load_codes(16'hE270);
        codes[0] = 2'b00; codes[1] = 2'b00; codes[2] = 2'b00; codes[3] = 2'b10;

        // ---- sweep, then keep GEN high for 40 cycles in total ----
        for (int i = 0; i < 40; i++) begin
            RD_IDX = 4'(i % 16);
            sb_push(0, 1, ov(1'b1, 1'b0, 1'b1, oh(codes[i % 16])),
                    (i < 16) ? "sweep" : "hold_read");
            sb_push(1, 1, ((i % 16) < 12) ? ov(1'b1, 1'b0, 1'b1, oh(codes[i % 16]))
                                          : ov(1'b1, 1'b0, 1'b1, 4'b0000),
                    (i < 16) ? "sweep_d12" : "hold_read_d12");
            tick();
        end

        // ---- GEN low one cycle, then high: refill ----
        RD_IDX = 4'd0;
        GEN = 1'b0;
        sb_push(0, 1, ov(1'b0, 1'b0, 1'b1, oh(codes[0])), "done_to_idle");
        sb_push(1, 1, ov(1'b0, 1'b0, 1'b1, oh(codes[0])), "done_to_idle_d12");
        tick();
        GEN = 1'b1;
        RD_IDX = 4'd5;
        sb_push(0, 1, busy7, "refill_start_prio");
        sb_push(1, 1, busy7, "refill_start_prio_d12");
        tick();
        load_codes(m_lfsr);
        for (int j = 1; j <= 16; j++) begin
            RD_IDX = 4'(j % 16);
            sb_push(0, 1, (j < 16) ? busy7 : ov(1'b1, 1'b0, 1'b1, 4'b0000), "refill_busy");
            if (j < 12)       sb_push(1, 1, busy7, "refill_busy_d12");
            else if (j == 12) sb_push(1, 1, ov(1'b1, 1'b0, 1'b1, 4'b0000), "refill_done_d12");
            tick();
        end
        for (int j = 0; j < 16; j++) begin
            RD_IDX = 4'(j);
            sb_push(0, 1, ov(1'b1, 1'b0, 1'b1, oh(codes[j])), "refill_read");
            sb_push(1, 1, (j < 12) ? ov(1'b1, 1'b0, 1'b1, oh(codes[j]))
                                   : ov(1'b1, 1'b0, 1'b1, 4'b0000), "refill_read_d12");
            tick();
        end

        // ---- abort a fill at its fifth cycle ----
        RD_IDX = 4'd0;
        GEN = 1'b0;
        sb_push(0, 1, ov(1'b0, 1'b0, 1'b1, oh(codes[0])), "idle_before_abort");
        tick();
        GEN = 1'b1;
        sb_push(0, 1, busy7, "abort_fill_start");
        sb_push(1, 1, busy7, "abort_fill_start_d12");
        tick();
        for (int j = 0; j < 4; j++) begin
            sb_push(0, 1, busy7, "abort_fill_busy");
            sb_push(1, 1, busy7, "abort_fill_busy_d12");
            tick();
        end
        GEN = 1'b0;
        sb_push(0, 1, zero7, "abort");
        sb_push(1, 1, zero7, "abort_d12");
        tick();
        for (int j = 0; j < 20; j++) begin
            RD_IDX = 4'(j % 16);
            sb_push(0, 1, zero7, "after_abort");
            sb_push(1, 1, zero7, "after_abort_d12");
            tick();
        end

        // ---- reset in the middle of a fill ----
        GEN = 1'b1;
        RD_IDX = 4'd0;
        sb_push(0, 1, busy7, "pre_reset_fill");
        tick(); tick(); tick();
        RESET_N = 1'b0;
        GEN = 1'b0;
        sb_push(0, 0, zero7, "reset_mid_fill");
        sb_push(1, 0, zero7, "reset_mid_fill_d12");
        sb_push(2, 0, 16'hACE1, "reset_mid_fill_lfsr");
        sb_push(3, 0, 16'h0001, "reset_mid_fill_seed0");
        tick(); tick();
        RESET_N = 1'b1;
        sb_push(0, 1, zero7, "post_reset_idle");
        tick();

        // ---- full fill, read, then reset in the middle of reading ----
        GEN = 1'b1;
        tick();
        load_codes(m_lfsr);
        RD_IDX = 4'd3;
        repeat (16) tick();
        sb_push(0, 1, ov(1'b1, 1'b0, 1'b1, oh(codes[3])), "read_before_reset");
        tick();
        tick();
        RESET_N = 1'b0;
        sb_push(0, 0, zero7, "reset_mid_read");
        sb_push(2, 0, 16'hACE1, "reset_mid_read_lfsr");
        tick();
        RESET_N = 1'b1;
        GEN = 1'b0;
        tick(); tick(); tick();

        while (q.size() > 0) begin
            n_bad++;
            $display("FAIL %s: check never reached (due cycle %0d)", q[0].name, q[0].cyc);
            q.delete(0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simon_seq_gen.md
Name: simon_seq_gen

Overview:
- Sequence source for the Simon memory game. It answers the game controller's rand phase by filling a colour-sequence RAM from a free-running LFSR, then handshakes completion on RAND_DONE.
- During the display and input phases it serves the stored colour at the controller's index as one-hot lines (YELLO/RE/BLU/GREE).
- It is the responder/reader end of the controller's rand_done and colour-lookup interface.

Parameters:
- DEPTH, 16: number of sequence entries (max game length).
- IDX_W, 4: index width; must satisfy 2**IDX_W >= DEPTH.
- SEED, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- GEN  in  1  fill request, level; driven from the controller's rand-state decode.
- RD_IDX  in  IDX_W  sequence index to read (controller I counter).
- RAND_DONE  out  1  fill complete; level, held while GEN stays high.
- BUSY  out  1  fill in progress.
- SEQ_VALID  out  1  a complete sequence is stored.
- YELLO  out  1  stored colour at RD_IDX is yellow.
- RE  out  1  stored colour at RD_IDX is red.
- BLU  out  1  stored colour at RD_IDX is blue.
- GREE  out  1  stored colour at RD_IDX is green.

Behaviour:
- Reset (async, RESET_N=0):
  - state=IDLE, lfsr=SEED (or 1 if SEED=0), wr_idx=0.
  - All outputs 0: RAND_DONE, BUSY, SEQ_VALID, and all four colour lines.
  - RAM contents are don't-care.
- LFSR:
  - 16-bit Galois, right shift, mask 16'hB400.
  - Advances on every clock edge regardless of state, so player START timing supplies entropy.
  - Never reaches 0.
- Colour code: lfsr[1:0] gives 00=green, 01=yellow, 10=blue, 11=red.
- FSM states: IDLE, FILL, DONE.
  - IDLE: when GEN=1, go to FILL at the next edge with wr_idx=0, BUSY=1, SEQ_VALID=0.
  - FILL: each edge writes mem[wr_idx] <= lfsr[1:0] (pre-advance value) and increments wr_idx.
  - FILL exit: on the edge that writes index DEPTH-1, go to DONE with RAND_DONE=1, SEQ_VALID=1, BUSY=0. Latency is DEPTH+1 edges from GEN sampled high to RAND_DONE high.
  - FILL abort: if GEN=0 during FILL, return to IDLE; SEQ_VALID stays 0 and partial data is invalid.
  - DONE: RAND_DONE=1 while GEN=1. When GEN=0, go to IDLE with RAND_DONE=0 at the next edge; SEQ_VALID stays 1.
  - DONE with GEN held high: no refill. A new fill needs GEN low for at least one cycle, then high again.
- Read port:
  - Registered with 1-cycle latency: colour lines reflect mem[RD_IDX] as sampled at the previous edge.
  - Exactly one colour line is high when SEQ_VALID=1 and RD_IDX < DEPTH; otherwise all four are 0.
  - All four are 0 during FILL.
- Simultaneous events:
  - GEN rising at the same edge as RD_IDX changes: fill start has priority and outputs go to 0.
  - Reset mid-fill: immediate IDLE; SEQ_VALID=0.
- Width: wr_idx is IDX_W bits; the comparison is against DEPTH-1, with no wrap past DEPTH.

Decomposition:
- Shared package simon_pkg:
  - colour code localparams COL_GREEN=2'b00, COL_YELLOW=2'b01, COL_BLUE=2'b10, COL_RED=2'b11;
  - LFSR mask 16'hB400;
  - FSM state encodings;
  - a one-hot decode function (2-bit code to {YELLO,RE,BLU,GREE}).
- One sub-module: simon_lfsr16, a free-running Galois LFSR with parameter SEED and zero-seed guard.

Test Plan:
- Reset release with SEED=16'hACE1, GEN=1 at the first edge -> lfsr walks 0xE270, 0x7138, 0x389C, 0x1C4E; mem[0..3] = green, green, green, blue; RAND_DONE rises after edge 17 (DEPTH=16).
- After fill, sweep RD_IDX 0..15 one per cycle -> each next cycle exactly one colour line high, matching a reference model; with RD_IDX=0, GREE=1 and YELLO=RE=BLU=0.
- Drop GEN at fill cycle 5 -> BUSY=0 and SEQ_VALID=0 next cycle; colour lines stay 0 for any RD_IDX; RAND_DONE never asserts.
- Hold GEN high 40 cycles after RAND_DONE -> RAND_DONE stays 1 and RAM unchanged; GEN low 1 cycle then high -> new fill with different data.
- Assert RESET_N=0 mid-fill and mid-read -> all outputs 0 asynchronously, lfsr=SEED; SEED=0 build -> lfsr starts at 16'h0001.
- DEPTH=12, IDX_W=4: RD_IDX=12..15 after fill -> all colour lines 0; RAND_DONE after 13 edges.
